// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enable/flush control, data-access done tracking and halt latch
// for the five-stage core. Optional perf counters under PIPE_CTRL_PERF_EN.
//
// Ports: CLK, nRST (sync, active-low); ihit/dhit memory completions;
// mem_dREN/mem_dWEN (EX/MEM request), wb_halt (MEM/WB halt),
// ex_branch_taken, ex_dREN, ex_wsel, id_rs, id_rt (hazard inputs);
// *_en/*_flush for the four pipe registers, dmemREN/dmemWEN/imemREN
// requests, halt (registered). With PIPE_CTRL_PERF_EN: stall_cnt, flush_cnt.
module pipe_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        wb_halt,
  input  logic        ex_branch_taken,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_wsel,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        imemREN,
  output logic        halt
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMDONE = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_n;
  logic       dacc;
  logic       step;
  logic       running;
  logic       live;
  logic       adv;
  logic       lu;

  assign dacc    = mem_dREN | mem_dWEN;
  // A completed access (MEMDONE) no longer blocks the step.
  assign step    = ihit & (~dacc | dhit | (state == MEMDONE));
  assign running = (state == RUN) | (state == MEMDONE);
  // wb_halt freezes everything in its own cycle so a younger
  // store never reaches memory.
  assign live    = nRST & running & ~wb_halt;
  assign adv     = live & step;

  assign lu = ex_dREN & (ex_wsel != 5'd0)
            & ((ex_wsel == id_rs) | (ex_wsel == id_rt));

  always_comb begin
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (adv) begin
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      // Branch squash wins over the load-use bubble.
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // No re-issue once the access has completed under a fetch miss.
  assign dmemREN = nRST & mem_dREN & (state == RUN) & ~wb_halt;
  assign dmemWEN = nRST & mem_dWEN & (state == RUN) & ~wb_halt;
  assign imemREN = nRST & (state != HALTED) & ~wb_halt;
  assign halt    = nRST & (state == HALTED);

  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (wb_halt)
          state_n = HALTED;
        else if (dacc & dhit & ~ihit)
          state_n = MEMDONE;
      end
      MEMDONE: begin
        if (wb_halt)
          state_n = HALTED;
        else if (step)
          state_n = RUN;
      end
      HALTED:  state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST)
      state <= RUN;
    else
      state <= state_n;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (running & ~step)
        stall_q <= stall_q + 32'd1;
      if (ifid_flush)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = nRST ? stall_q : 32'd0;
  assign flush_cnt = nRST ? flush_q : 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; directed scenarios
// then randomized cycles against a behavioural model.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       whalt;
    logic       br;
    logic       exdren;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
  } stim_t;

  typedef struct {
    string       name;
    logic [11:0] ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dhit, mem_dREN, mem_dWEN, wb_halt;
  logic       ex_branch_taken, ex_dREN;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic       ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       dmemREN, dmemWEN, imemREN, halt;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .wb_halt(wb_halt),
    .ex_branch_taken(ex_branch_taken), .ex_dREN(ex_dREN),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .imemREN(imemREN), .halt(halt)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  exp_t        sbq[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          m_halted = 1'b0;
  bit          m_done   = 1'b0;
  int unsigned m_stall  = 0;
  int unsigned m_flush  = 0;

  // Model: the pipeline moves when the fetch is back and the data
  // access (if any) is back now or was already back earlier.
  task automatic cyc(input string nm, input stim_t s);
    exp_t e;
    bit ie, de, xe, we, ifl, dfl, dr, dw, im, h;
    bit dacc, wait_data, go;
    @(negedge CLK);
    nRST = s.rst_n; ihit = s.ihit; dhit = s.dhit;
    mem_dREN = s.dren; mem_dWEN = s.dwen; wb_halt = s.whalt;
    ex_branch_taken = s.br; ex_dREN = s.exdren;
    ex_wsel = s.wsel; id_rs = s.rs; id_rt = s.rt;
    {ie, de, xe, we, ifl, dfl, dr, dw, im, h} = '0;
    e.name = nm;
    e.sc = s.rst_n ? m_stall : 32'd0;
    e.fc = s.rst_n ? m_flush : 32'd0;
    dacc = s.dren || s.dwen;
    wait_data = dacc && !s.dhit && !m_done;
    go = s.ihit && !wait_data;
    if (!s.rst_n) begin
      m_halted = 0; m_done = 0; m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
      h = 1;
    end else begin
      if (!s.whalt) begin
        dr = s.dren && !m_done;
        dw = s.dwen && !m_done;
        im = 1;
        if (go) begin
          {ie, de, xe, we} = 4'hf;
          if (s.br) begin
            ifl = 1; dfl = 1;
          end else if (s.exdren && s.wsel != 0 &&
                       (s.wsel == s.rs || s.wsel == s.rt)) begin
            ie = 0; dfl = 1;
          end
        end
      end
      if (!go) m_stall++;
      if (ifl) m_flush++;
      if (s.whalt) m_halted = 1;
      else if (m_done) m_done = !go;
      else m_done = dacc && s.dhit && !s.ihit;
    end
    e.ctl = {ie, de, xe, we, ifl, dfl, 1'b0, 1'b0, dr, dw, im, h};
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [11:0] act;
    forever begin
      @(negedge CLK);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = {ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               dmemREN, dmemWEN, imemREN, halt};
        n_total++;
        if (act === e.ctl) n_pass++;
        else $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
`ifdef PIPE_CTRL_PERF_EN
        n_total++;
        if (stall_cnt === e.sc && flush_cnt === e.fc) n_pass++;
        else $display("FAIL %s cnt: got %0d/%0d want %0d/%0d",
                      e.name, stall_cnt, flush_cnt, e.sc, e.fc);
`endif
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  initial begin : stim
    stim_t s;
    nRST = 0; ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
    wb_halt = 0; ex_branch_taken = 0; ex_dREN = 0;
    ex_wsel = 0; id_rs = 0; id_rt = 0;

    s = '1; s.rst_n = 1'b0;
    cyc("reset0", s);
    cyc("reset1", s);
    s = idle(); s.ihit = 1;
    cyc("run", s);

    s = idle(); s.ihit = 1; s.dren = 1;
    for (int i = 0; i < 3; i++) cyc("dmiss", s);
    s.dhit = 1;
    cyc("dmiss_hit", s);

    s = idle(); s.dwen = 1; s.dhit = 1;
    cyc("st_c0", s);
    s.dhit = 0;
    cyc("st_c1", s);
    s.ihit = 1;
    cyc("st_c2", s);

    s = idle(); s.ihit = 1; s.exdren = 1; s.wsel = 8; s.rt = 8; s.rs = 3;
    cyc("loaduse", s);
    s.br = 1;
    cyc("lu_branch", s);
    s.br = 0; s.wsel = 0;
    cyc("lu_wsel0", s);

    s = idle(); s.ihit = 1;
    for (int i = 0; i < 5; i++) begin
      s.ihit = 0;
      cyc("stall", s);
    end
    s.ihit = 1; s.br = 1;
    cyc("br0", s);
    cyc("br1", s);

    s = idle(); s.ihit = 1; s.dwen = 1; s.whalt = 1;
    cyc("halt_c0", s);
    s.whalt = 0;
    for (int i = 0; i < 3; i++) cyc("halted", s);
    s.rst_n = 0;
    cyc("halt_rst", s);
    cyc("post_rst", idle());

    s = idle(); s.ihit = 0; s.dren = 1; s.dhit = 1;
    cyc("md_enter", s);
    s.rst_n = 0;
    cyc("md_rst", s);
    s = idle(); s.dren = 1; s.ihit = 1;
    cyc("md_drop", s);

    for (int i = 0; i < 600; i++) begin
      s = stim_t'(23'($urandom));
      s.rst_n = ($urandom_range(0, 31) != 0);
      s.whalt = ($urandom_range(0, 23) == 0);
      s.wsel  = 5'($urandom_range(0, 3));
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      cyc("rand", s);
    end

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge CLK);
    @(negedge CLK);
    #4;
    n_total++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
